// File: rtl/exception_unit.sv
// exception_unit: prioritised exception/interrupt capture FSM holding epc and cause for the handler.
// Interrupt support (ext_irq qualified by instr_boundary) is built only with macro EXC_IRQ_EN defined.
module exception_unit #(
  parameter logic [31:0] HANDLER_BASE = 32'h0000_0080
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic        overflow,
  input  logic        bad_opcode,
  input  logic        ext_irq,
  input  logic        instr_boundary,
  input  logic        exc_ack,
  input  logic        rfe,
  output logic        exc_req,
  output logic [31:0] exc_vector,
  output logic [31:0] epc,
  output logic [1:0]  cause,
  output logic        in_handler,
  output logic        double_fault
);
  typedef enum logic [1:0] {IDLE, REQ, HANDLER} state_t;
  state_t state, state_nx;
  logic [1:0] code;
`ifdef EXC_IRQ_EN
  assign code = overflow ? 2'd1 : bad_opcode ? 2'd2 : (ext_irq & instr_boundary) ? 2'd3 : 2'd0;
`else
  logic unused_irq;
  assign unused_irq = ext_irq ^ instr_boundary;
  assign code = overflow ? 2'd1 : bad_opcode ? 2'd2 : 2'd0;
`endif
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (code != 2'd0 ? REQ : IDLE) :
               state == REQ  ? (exc_ack ? HANDLER : REQ) :
               (rfe ? IDLE : HANDLER);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      epc          <= '0;
      cause        <= '0;
      double_fault <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && code != 2'd0) begin
        cause <= code;
        epc   <= code == 2'd3 ? pc_in : pc_in - 32'd4;
      end
      if (state == HANDLER && rfe) cause <= 2'd0;
      if (state == HANDLER && (overflow | bad_opcode)) double_fault <= 1'b1;
    end
  end
  assign exc_req    = state == REQ;
  assign in_handler = state == HANDLER;
  assign exc_vector = HANDLER_BASE + {26'd0, cause, 4'd0};
endmodule

// File: tb/tb_exception_unit.sv
// tb_exception_unit: directed steps with a scoreboard queue of expected post-edge outputs.
module tb_exception_unit;
  logic        clock = 1'b0, reset = 1'b1;
  logic [31:0] pc_in = '0;
  logic        overflow = 1'b0, bad_opcode = 1'b0, ext_irq = 1'b0, instr_boundary = 1'b0;
  logic        exc_ack = 1'b0, rfe = 1'b0;
  logic        exc_req, in_handler, double_fault;
  logic [31:0] exc_vector, epc;
  logic [1:0]  cause;
  int          n_tests = 0, n_fail = 0;

  typedef struct {
    string       tag;
    logic        req;
    logic [1:0]  cause;
    logic [31:0] epc;
    logic        inh;
    logic        df;
  } exp_t;
  exp_t sb[$];

  exception_unit dut (
    .clock(clock), .reset(reset), .pc_in(pc_in), .overflow(overflow), .bad_opcode(bad_opcode),
    .ext_irq(ext_irq), .instr_boundary(instr_boundary), .exc_ack(exc_ack), .rfe(rfe),
    .exc_req(exc_req), .exc_vector(exc_vector), .epc(epc), .cause(cause),
    .in_handler(in_handler), .double_fault(double_fault)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input string fld, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, fld, act, exp);
    end
  endtask

  // drive one cycle of inputs, queue the expected outputs after the edge, then compare
  task automatic step(input string tag, input logic rst, input logic [31:0] pc,
                      input logic ov, input logic bo, input logic irq, input logic ib,
                      input logic ack, input logic rf,
                      input logic e_req, input logic [1:0] e_cause, input logic [31:0] e_epc,
                      input logic e_inh, input logic e_df);
    exp_t e, g;
    reset = rst; pc_in = pc; overflow = ov; bad_opcode = bo; ext_irq = irq;
    instr_boundary = ib; exc_ack = ack; rfe = rf;
    e.tag = tag; e.req = e_req; e.cause = e_cause; e.epc = e_epc; e.inh = e_inh; e.df = e_df;
    sb.push_back(e);
    @(posedge clock);
    #1;
    g = sb.pop_front();
    chk(g.tag, "exc_req", {31'd0, exc_req}, {31'd0, g.req});
    chk(g.tag, "cause", {30'd0, cause}, {30'd0, g.cause});
    chk(g.tag, "epc", epc, g.epc);
    chk(g.tag, "exc_vector", exc_vector, 32'h0000_0080 + 32'(g.cause) * 32'd16);
    chk(g.tag, "in_handler", {31'd0, in_handler}, {31'd0, g.inh});
    chk(g.tag, "double_fault", {31'd0, double_fault}, {31'd0, g.df});
  endtask

  initial begin
    //    tag           rst pc            ov bo ir ib ak rf   req cause epc           inh df
    step("reset",       1, 32'h10,        0, 0, 0, 0, 0, 0,   0, 2'd0, 32'h0,        0, 0);
    step("idle",        0, 32'h10,        0, 0, 0, 0, 0, 0,   0, 2'd0, 32'h0,        0, 0);
    step("ovf",         0, 32'h10,        1, 0, 0, 0, 0, 0,   1, 2'd1, 32'hC,        0, 0);
    step("req_ign_bo",  0, 32'h20,        0, 1, 0, 0, 0, 0,   1, 2'd1, 32'hC,        0, 0);
    step("req_ign_irq", 0, 32'h20,        0, 0, 1, 1, 0, 0,   1, 2'd1, 32'hC,        0, 0);
    step("req_rfe_ign", 0, 32'h20,        0, 0, 0, 0, 0, 1,   1, 2'd1, 32'hC,        0, 0);
    step("ack",         0, 32'h20,        0, 0, 0, 0, 1, 0,   0, 2'd1, 32'hC,        1, 0);
    step("hnd_ack_ign", 0, 32'h20,        0, 0, 0, 0, 1, 0,   0, 2'd1, 32'hC,        1, 0);
    step("rfe",         0, 32'h20,        0, 0, 0, 0, 0, 1,   0, 2'd0, 32'hC,        0, 0);
    step("idle_rfe",    0, 32'h20,        0, 0, 0, 0, 0, 1,   0, 2'd0, 32'hC,        0, 0);
    step("idle_ack",    0, 32'h20,        0, 0, 0, 0, 1, 0,   0, 2'd0, 32'hC,        0, 0);
    step("prio",        0, 32'h40,        1, 1, 1, 1, 0, 0,   1, 2'd1, 32'h3C,       0, 0);
    step("prio_ack",    0, 32'h40,        0, 0, 1, 1, 1, 0,   0, 2'd1, 32'h3C,       1, 0);
    step("hnd_irq_msk", 0, 32'h40,        0, 0, 1, 1, 0, 0,   0, 2'd1, 32'h3C,       1, 0);
    step("prio_rfe",    0, 32'h44,        0, 0, 1, 0, 0, 1,   0, 2'd0, 32'h3C,       0, 0);
    step("irq_no_ib",   0, 32'h44,        0, 0, 1, 0, 0, 0,   0, 2'd0, 32'h3C,       0, 0);
`ifdef EXC_IRQ_EN
    step("irq",         0, 32'h48,        0, 0, 1, 1, 0, 0,   1, 2'd3, 32'h48,       0, 0);
    step("irq_ack",     0, 32'h48,        0, 0, 0, 0, 1, 0,   0, 2'd3, 32'h48,       1, 0);
    step("irq_rfe",     0, 32'h48,        0, 0, 0, 0, 0, 1,   0, 2'd0, 32'h48,       0, 0);
`else
    for (int i = 0; i < 10; i++)
      step("irq_off",   0, 32'h48,        0, 0, 1, 1, 0, 0,   0, 2'd0, 32'h3C,       0, 0);
    step("irq_off_end", 0, 32'h48,        0, 0, 0, 0, 0, 0,   0, 2'd0, 32'h3C,       0, 0);
`endif
    step("bad_wrap",    0, 32'h0,         0, 1, 0, 0, 0, 0,   1, 2'd2, 32'hFFFF_FFFC, 0, 0);
    step("bad_ack",     0, 32'h8,         0, 0, 0, 0, 1, 0,   0, 2'd2, 32'hFFFF_FFFC, 1, 0);
    step("dbl_fault",   0, 32'h8,         0, 1, 0, 0, 0, 0,   0, 2'd2, 32'hFFFF_FFFC, 1, 1);
    step("dbl_ovf",     0, 32'hC,         1, 0, 0, 0, 0, 0,   0, 2'd2, 32'hFFFF_FFFC, 1, 1);
    step("dbl_rfe",     0, 32'hC,         0, 0, 0, 0, 0, 1,   0, 2'd0, 32'hFFFF_FFFC, 0, 1);
    step("dbl_sticky",  0, 32'hC,         0, 0, 0, 0, 0, 0,   0, 2'd0, 32'hFFFF_FFFC, 0, 1);
    step("bad2",        0, 32'h104,       0, 1, 0, 0, 0, 0,   1, 2'd2, 32'h100,      0, 1);
    step("rst_in_req",  1, 32'h104,       1, 0, 0, 0, 1, 0,   0, 2'd0, 32'h0,        0, 0);
    step("post_rst",    0, 32'h104,       0, 0, 0, 0, 1, 0,   0, 2'd0, 32'h0,        0, 0);
    step("ovf3",        0, 32'h200,       1, 0, 0, 0, 0, 0,   1, 2'd1, 32'h1FC,      0, 0);
    step("ovf3_ack",    0, 32'h200,       0, 0, 0, 0, 1, 0,   0, 2'd1, 32'h1FC,      1, 0);
    step("rst_in_hnd",  1, 32'h200,       0, 1, 0, 0, 0, 1,   0, 2'd0, 32'h0,        0, 0);
    reset = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/exception_unit.md
EXCEPTION_UNIT -- requirements
Module: exception_unit

Interface
REQ-001 The block SHALL use one clock and a reset that is synchronous and active-high, with the ports named clock and reset.
REQ-002 Parameter HANDLER_BASE, default 32'h0000_0080, SHALL set the base address of the exception handler vectors.
REQ-003 Port clock, input, 1 bit: system clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous active-high reset.
REQ-005 Port pc_in, input, 32 bits: current PC register value (already incremented by 4 after fetch).
REQ-006 Port overflow, input, 1 bit: single-cycle ALU overflow pulse from the control unit's execute state.
REQ-007 Port bad_opcode, input, 1 bit: single-cycle invalid-opcode pulse from decode.
REQ-008 Port ext_irq, input, 1 bit: level-sensitive external interrupt.
REQ-009 Port instr_boundary, input, 1 bit: high for the cycle in which the control unit is at the first fetch state.
REQ-010 Port exc_ack, input, 1 bit: the control unit has loaded exc_vector into PC.
REQ-011 Port rfe, input, 1 bit: single-cycle pulse marking a return-from-exception.
REQ-012 Port exc_req, output, 1 bit: request for the control unit to redirect PC.
REQ-013 Port exc_vector, output, 32 bits: redirect target.
REQ-014 Port epc, output, 32 bits: saved return address.
REQ-015 Port cause, output, 2 bits: exception code (0 = none, 1 = overflow, 2 = bad opcode, 3 = interrupt).
REQ-016 Port in_handler, output, 1 bit: high while the FSM is in HANDLER.
REQ-017 Port double_fault, output, 1 bit: sticky flag for a synchronous exception raised inside the handler.

Function
REQ-018 The FSM SHALL have three states: IDLE, REQ and HANDLER.
REQ-019 In IDLE, the block SHALL select one event by fixed priority: overflow first, then bad_opcode, then ext_irq qualified by instr_boundary.
REQ-020 On accepting an event in IDLE, the block SHALL in the same edge:
- load cause with the event code;
- load epc with pc_in-4 for codes 1 and 2, or with pc_in for code 3 (modulo 2^32);
- go to REQ.
REQ-021 exc_req SHALL be registered, equal to 1 exactly while the FSM is in REQ, so it is first high one cycle after the event.
REQ-022 In REQ, exc_req SHALL stay high until exc_ack is sampled high; that edge SHALL move the FSM to HANDLER.
REQ-023 In REQ, new overflow, bad_opcode and ext_irq inputs SHALL be ignored.
REQ-024 exc_vector SHALL be driven combinationally as HANDLER_BASE + (cause << 4), modulo 2^32.
REQ-025 In HANDLER:
- ext_irq SHALL be masked;
- an overflow or bad_opcode pulse SHALL set double_fault and SHALL NOT change epc or cause.
REQ-026 rfe in HANDLER SHALL, at the next edge, clear cause to 0 and move the FSM to IDLE; epc SHALL be held.
REQ-027 rfe outside HANDLER and exc_ack outside REQ SHALL be ignored.
REQ-028 A simultaneous synchronous exception and ext_irq SHALL take the synchronous exception.
- ext_irq is not latched, so a still-asserted irq is taken at the first instr_boundary after return to IDLE.
REQ-029 double_fault SHALL clear only on reset.

Reset
REQ-030 While reset is high at a clock edge, the block SHALL set:
- FSM = IDLE;
- exc_req = 0, epc = 0, cause = 0;
- in_handler = 0, double_fault = 0;
- exc_vector therefore = HANDLER_BASE.
REQ-031 Reset SHALL take precedence over every other input, including in REQ and HANDLER, and SHALL discard any pending request.

Configuration
REQ-032 With macro EXC_IRQ_EN defined, ext_irq SHALL behave as specified above.
REQ-033 Without EXC_IRQ_EN, ext_irq SHALL be ignored, cause 3 SHALL never be produced, and no interrupt-qualification logic SHALL be synthesized.

Verification
REQ-034 The bench SHALL cover: pc_in=32'h0000_0010, overflow pulse → next cycle exc_req=1, cause=1, epc=32'h0000_000C, exc_vector=32'h0000_0090.
REQ-035 The bench SHALL cover: exc_ack after 3 cycles → exc_req drops and in_handler=1 the next cycle; rfe → cause=0, in_handler=0, epc still 32'h0000_000C.
REQ-036 The bench SHALL cover: overflow, bad_opcode and ext_irq in the same cycle with instr_boundary=1 → cause=1; after rfe with ext_irq held and instr_boundary → cause=3, epc=pc_in, exc_vector=32'h0000_00B0.
REQ-037 The bench SHALL cover: bad_opcode in HANDLER → double_fault=1, epc and cause unchanged; double_fault remains 1 after rfe.
REQ-038 The bench SHALL cover: reset asserted while in REQ → next cycle exc_req=0, cause=0, exc_vector=32'h0000_0080.
REQ-039 The bench SHALL cover a build without EXC_IRQ_EN: ext_irq=1 with instr_boundary=1 for 10 cycles → exc_req stays 0.
